// File: rtl/sram_like_mem_slave.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface, backed by a word RAM.
// Optional macro SRAM_SLAVE_STALL_EN: an LFSR randomly withholds addr_ok in IDLE.
module sram_like_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           ram [DEPTH];
  logic [3:0]            mask;
  logic [31:0]           mask32;
  logic                  grant;
  logic                  unused_addr;

  // Upper address bits alias onto the RAM; only the index and lane bits matter.
  assign unused_addr = ^{1'b0, addr};

`ifdef SRAM_SLAVE_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign grant = ~lfsr[0];
`else
  assign grant = 1'b1;
`endif

  assign addr_ok = ~rst & (state == IDLE) & req & grant;
  assign data_ok = ~rst & (state == BUSY) & (cnt == '0);
  assign rdata   = (data_ok && !wr_q) ? ram[idx_q] : '0;

  always_comb begin
    mask = '0;
    unique case (size_q)
      2'b00:   mask = 4'b0001 << off_q;
      2'b01:   mask = off_q[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    for (int unsigned i = 0; i < 4; i++) mask32[i*8 +: 8] = {8{mask[i]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (addr_ok) begin
            wr_q    <= wr;
            size_q  <= size;
            off_q   <= addr[1:0];
            idx_q   <= addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (wr_q) wr_count <= wr_count + 32'd1;
            else      rd_count <= rd_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (data_ok && wr_q) begin
      ram[idx_q] <= (ram[idx_q] & ~mask32) | (wdata_q & mask32);
    end
  end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed bench for sram_like_mem_slave: main instance (LATENCY=3) plus a LATENCY=1 instance.
module tb_sram_like_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, rd_count, wr_count;
  logic        addr_ok, data_ok;

  logic        req1 = 1'b0;
  logic [31:0] rdata1, rd_count1, wr_count1;
  logic        addr_ok1, data_ok1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  sram_like_mem_slave #(.ADDR_WIDTH(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(1'b0), .size(2'b10), .addr(32'h0),
    .wdata(32'h0), .rdata(rdata1), .addr_ok(addr_ok1), .data_ok(data_ok1),
    .rd_count(rd_count1), .wr_count(wr_count1)
  );

  // Issues one transaction; returns rdata seen in the data_ok cycle and cycles from accept.
  task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    n = 0; #1;
    while (!addr_ok && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout addr=%h got addr_ok=%b want 1", a, addr_ok);
    end
    @(negedge clk);
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    lat = 1; #1;
    while (!data_ok && lat < 20) begin @(negedge clk); #1; lat++; end
    rd = rdata;
    checks++;
    if (data_ok !== 1'b1) begin
      failures++;
      $display("FAIL data_ok_timeout addr=%h got data_ok=%b want 1", a, data_ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; req1 = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({addr_ok, data_ok, addr_ok1, data_ok1} !== 4'b0) begin
      failures++;
      $display("FAIL reset_handshake got %b want 0000", {addr_ok, data_ok, addr_ok1, data_ok1});
    end
    checks++;
    if ({rdata, rd_count, wr_count} !== 96'h0) begin
      failures++;
      $display("FAIL reset_values got rdata=%h rd=%0d wr=%0d want 0", rdata, rd_count, wr_count);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_read_after_reset();
    logic [31:0] rd; int lat;
    txn(1'b0, 2'b10, 32'h0000_0010, 32'h0, rd, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL read_latency got %0d want 3", lat); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL read_zero got %h want 00000000", rd); end
    @(negedge clk); #1;
    checks++;
    if (rd_count !== 32'd1) begin failures++; $display("FAIL rd_count_1 got %0d want 1", rd_count); end
  endtask

  task automatic test_word_write_read();
    logic [31:0] rd; int lat;
    txn(1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF, rd, lat);
    checks++;
    if (rd !== 32'h0 || lat !== 3) begin
      failures++; $display("FAIL write_resp got rdata=%h lat=%0d want 0 / 3", rd, lat);
    end
    txn(1'b0, 2'b00, 32'h0000_0020, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_rw got %h want deadbeef", rd); end
    @(negedge clk); #1;
    checks++;
    if (wr_count !== 32'd1 || rd_count !== 32'd2) begin
      failures++; $display("FAIL counts_rw got wr=%0d rd=%0d want 1 / 2", wr_count, rd_count);
    end
  endtask

  task automatic test_partial_writes();
    logic [31:0] rd; int lat;
    txn(1'b1, 2'b00, 32'h0000_0022, 32'h0055_0000, rd, lat);
    txn(1'b1, 2'b01, 32'h0000_0020, 32'h0000_1234, rd, lat);
    txn(1'b0, 2'b10, 32'h0000_0020, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDE55_1234) begin failures++; $display("FAIL byte_half got %h want de551234", rd); end
    txn(1'b1, 2'b11, 32'h0000_0030, 32'hAABB_CCDD, rd, lat);
    txn(1'b1, 2'b01, 32'h0000_0033, 32'h1122_0000, rd, lat);
    txn(1'b1, 2'b00, 32'h0000_0031, 32'h0000_EE00, rd, lat);
    txn(1'b0, 2'b00, 32'h0000_0030, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1122_EEDD) begin failures++; $display("FAIL size11_upper_half got %h want 1122eedd", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if (addr_ok1 !== (i % 2 == 0) || data_ok1 !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL b2b_cycle%0d got addr_ok=%b data_ok=%b want %b %b",
                 i, addr_ok1, data_ok1, (i % 2 == 0), (i % 2 == 1));
      end
    end
    @(negedge clk);
    req1 = 1'b0; #1;
    checks++;
    if (rd_count1 !== 32'd4) begin failures++; $display("FAIL b2b_count got %0d want 4", rd_count1); end
  endtask

  task automatic test_mid_busy_reset();
    logic [31:0] rd; int lat, n, seen;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'hCAFE_F00D;
    n = 0; #1;
    while (!addr_ok && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (addr_ok !== 1'b1) begin failures++; $display("FAIL mid_reset_accept got %b want 1", addr_ok); end
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (data_ok) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0 || wr_count !== 32'd0) begin
      failures++; $display("FAIL mid_reset_drop got data_ok_count=%0d wr=%0d want 0 / 0", seen, wr_count);
    end
    txn(1'b0, 2'b10, 32'h40, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL mid_reset_ram40 got %h want 0", rd); end
    txn(1'b0, 2'b10, 32'h20, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_clears_ram got %h want 0", rd); end
  endtask

  task automatic test_aliasing();
    logic [31:0] rd; int lat;
    txn(1'b1, 2'b10, 32'h0001_4008, 32'h1111_2222, rd, lat);
    txn(1'b0, 2'b10, 32'h0000_4008, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1111_2222) begin failures++; $display("FAIL alias_4008 got %h want 11112222", rd); end
    txn(1'b0, 2'b10, 32'h0000_0008, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1111_2222) begin failures++; $display("FAIL alias_0008 got %h want 11112222", rd); end
    @(negedge clk); #1;
    checks++;
    if (wr_count !== 32'd1 || rd_count !== 32'd4) begin
      failures++; $display("FAIL alias_counts got wr=%0d rd=%0d want 1 / 4", wr_count, rd_count);
    end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_word_write_read();
    test_partial_writes();
    test_back_to_back();
    test_mid_busy_reset();
    test_aliasing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
